// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU front end:
// next-PC encodings, reset/halt defaults and instruction field layout.
package cpu_pkg;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JR     = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [5:0]  HALT_OPCODE_DEF = 6'b111111;
  localparam logic [31:0] RESET_PC_DEF    = 32'h0000_0000;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [10:0] lo;
  } instr_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory port of the fetch stage.
// Read data is combinational from the address.
interface fetch_unit_if;
  logic [31:0] ins_addr;
  logic        ins_rd;
  logic [31:0] ins_rdata;

  modport master (
    output ins_addr,
    output ins_rd,
    input  ins_rdata
  );

  modport slave (
    input  ins_addr,
    input  ins_rd,
    output ins_rdata
  );
endinterface

// File: rtl/next_pc_mux.sv
// Next-PC target selection and word alignment.
// Misaligned targets are forced down to the word boundary.
module next_pc_mux
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] pc4,
  input  logic [31:0] ext_imm,
  input  logic [31:0] rs_data,
  input  logic [25:0] jaddr,
  input  logic [1:0]  pc_src,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] raw;

  always_comb begin
    raw = pc + 32'd4;
    unique case (pc_src)
      PC_NEXT:   raw = pc + 32'd4;
      PC_BRANCH: raw = pc4 + (ext_imm << 2);
      PC_JR:     raw = rs_data;
      PC_JUMP:   raw = {pc4[31:28], jaddr, 2'b00};
      default:   raw = pc + 32'd4;
    endcase
  end

  assign misaligned = |raw[1:0];
  assign target     = {raw[31:2], 2'b00};

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, IR, latched PC+4, sticky halt/misalign
// flags and retired-fetch counter.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [5:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCWre,
  input  logic         IRWre,
  input  logic         InsMemRW,
  input  logic [1:0]   PCSrc,
  input  logic [31:0]  ext_imm,
  input  logic [31:0]  rs_data,
  fetch_unit_if.master imem,
  output logic [31:0]  pc,
  output logic [31:0]  pc4,
  output logic [31:0]  ir,
  output logic [5:0]   opcode,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [15:0]  imm16,
  output logic [25:0]  jaddr,
  output logic         halted,
  output logic         misalign,
  output logic [31:0]  instr_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  instr_t      ir_q, ir_d;
  logic [31:0] cnt_q, cnt_d;
  logic        halted_q, halted_d;
  logic        misalign_q, misalign_d;

  logic [31:0] target;
  logic        tgt_mis;
  logic        ld_ir;
  logic        wr_pc;

  next_pc_mux u_next_pc (
    .pc         (pc_q),
    .pc4        (pc4_q),
    .ext_imm    (ext_imm),
    .rs_data    (rs_data),
    .jaddr      (jaddr),
    .pc_src     (PCSrc),
    .target     (target),
    .misaligned (tgt_mis)
  );

  assign ld_ir = IRWre & InsMemRW & ~halted_q;
  assign wr_pc = PCWre & ~halted_q;

  always_comb begin
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    ir_d       = ir_q;
    cnt_d      = cnt_q;
    misalign_d = misalign_q;
    halted_d   = halted_q | (ir_q.opcode == HALT_OPCODE);
    if (ld_ir) begin
      ir_d  = instr_t'(imem.ins_rdata);
      pc4_d = pc_q + 32'd4;
      cnt_d = cnt_q + 32'd1;
    end
    if (wr_pc) begin
      pc_d       = target;
      misalign_d = misalign_q | tgt_mis;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      pc4_q      <= '0;
      ir_q       <= '0;
      cnt_q      <= '0;
      halted_q   <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      halted_q   <= halted_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem.ins_addr = pc_q;
  assign imem.ins_rd   = InsMemRW & ~halted_q;

  assign pc          = pc_q;
  assign pc4         = pc4_q;
  assign ir          = ir_q;
  assign opcode      = ir_q.opcode;
  assign rs          = ir_q.rs;
  assign rt          = ir_q.rt;
  assign rd          = ir_q.rd;
  assign imm16       = ir[15:0];
  assign jaddr       = ir[25:0];
  assign halted      = halted_q;
  assign misalign    = misalign_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed test of fetch_unit: reset, fetch, branch, jump,
// jr misalignment, simultaneous update and halt.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_wre = 1'b0;
  logic        ir_wre = 1'b0;
  logic        mem_rw = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] ext_imm = '0;
  logic [31:0] rs_data = '0;

  logic [31:0] pc, pc4, ir, instr_count;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic        halted, misalign;

  int n_chk = 0;
  int n_err = 0;

  fetch_unit_if imem ();

  fetch_unit dut (
    .clk         (clk),
    .reset       (rst_n),
    .PCWre       (pc_wre),
    .IRWre       (ir_wre),
    .InsMemRW    (mem_rw),
    .PCSrc       (pc_src),
    .ext_imm     (ext_imm),
    .rs_data     (rs_data),
    .imem        (imem.master),
    .pc          (pc),
    .pc4         (pc4),
    .ir          (ir),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm16       (imm16),
    .jaddr       (jaddr),
    .halted      (halted),
    .misalign    (misalign),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_wre = 1'b0;
    ir_wre = 1'b0;
  endtask

  initial begin
    imem.ins_rdata = '0;
    #3;
    check("rst_pc", pc, 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_pc4", pc4, 32'h0);
    check("rst_cnt", instr_count, 32'h0);
    check("rst_flags", 32'({halted, misalign}), 32'h0);
    #5 rst_n = 1'b1;

    // sequential fetch
    mem_rw = 1'b1;
    imem.ins_rdata = 32'h0022_0820;
    ir_wre = 1'b1;
    tick();
    ir_wre = 1'b0;
    pc_wre = 1'b1;
    pc_src = PC_NEXT;
    tick();
    idle();
    check("seq_ir", ir, 32'h0022_0820);
    check("seq_pc4", pc4, 32'h4);
    check("seq_pc", pc, 32'h4);
    check("seq_cnt", instr_count, 32'd1);
    check("seq_fields", 32'({opcode, rs, rt, rd}),
          32'({6'd0, 5'd1, 5'd2, 5'd1}));
    check("seq_imm16", 32'(imm16), 32'h0820);
    check("seq_addr", imem.ins_addr, 32'h4);
    check("seq_rd", 32'(imem.ins_rd), 32'h1);

    // branch back from 0x10
    pc_wre = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    idle();
    check("br_pc0", pc, 32'h10);
    imem.ins_rdata = 32'h1000_FFFE;
    ir_wre = 1'b1;
    tick();
    idle();
    check("br_pc4", pc4, 32'h14);
    ext_imm = 32'hFFFF_FFFE;
    pc_src = PC_BRANCH;
    pc_wre = 1'b1;
    tick();
    idle();
    check("br_pc", pc, 32'h0C);
    check("br_mis", 32'(misalign), 32'h0);

    // jump
    imem.ins_rdata = 32'h0800_0010;
    ir_wre = 1'b1;
    tick();
    idle();
    check("j_jaddr", 32'(jaddr), 32'h10);
    pc_src = PC_JUMP;
    pc_wre = 1'b1;
    tick();
    idle();
    check("j_pc", pc, 32'h40);
    check("j_cnt", instr_count, 32'd3);

    // asynchronous reset mid-cycle
    #3 rst_n = 1'b0;
    #1;
    check("arst_pc", pc, 32'h0);
    check("arst_ir", ir, 32'h0);
    check("arst_cnt", instr_count, 32'h0);
    check("arst_pc4", pc4, 32'h0);
    #2 rst_n = 1'b1;

    // PC and IR written on the same edge
    imem.ins_rdata = 32'h2000_0005;
    ext_imm = 32'h1;
    pc_src = PC_BRANCH;
    pc_wre = 1'b1;
    ir_wre = 1'b1;
    tick();
    idle();
    check("sim_pc", pc, 32'h4);
    check("sim_pc4", pc4, 32'h4);
    check("sim_ir", ir, 32'h2000_0005);
    check("sim_cnt", instr_count, 32'd1);

    // IRWre without InsMemRW
    mem_rw = 1'b0;
    imem.ins_rdata = 32'hDEAD_BEEF;
    ir_wre = 1'b1;
    #1;
    check("nord_rd", 32'(imem.ins_rd), 32'h0);
    tick();
    idle();
    check("nord_ir", ir, 32'h2000_0005);
    check("nord_cnt", instr_count, 32'd1);
    check("nord_pc4", pc4, 32'h4);
    mem_rw = 1'b1;

    // jr to a misaligned address
    rs_data = 32'h0000_0022;
    pc_src = PC_JR;
    pc_wre = 1'b1;
    tick();
    idle();
    check("jr_pc", pc, 32'h20);
    check("jr_mis", 32'(misalign), 32'h1);
    imem.ins_rdata = 32'h0;
    pc_src = PC_NEXT;
    for (int i = 0; i < 10; i++) begin
      pc_wre = 1'b1;
      ir_wre = 1'b1;
      tick();
    end
    idle();
    check("jr_mis_sticky", 32'(misalign), 32'h1);
    check("jr_pc_after", pc, 32'h48);
    check("jr_cnt_after", instr_count, 32'd11);

    // halt
    imem.ins_rdata = 32'hFC00_0000;
    ir_wre = 1'b1;
    tick();
    idle();
    check("h_op", 32'(opcode), 32'h3F);
    check("h_not_yet", 32'(halted), 32'h0);
    tick();
    check("h_set", 32'(halted), 32'h1);
    imem.ins_rdata = 32'h1234_5678;
    pc_wre = 1'b1;
    ir_wre = 1'b1;
    tick();
    tick();
    check("h_pc", pc, 32'h48);
    check("h_ir", ir, 32'hFC00_0000);
    check("h_cnt", instr_count, 32'd12);
    check("h_pc4", pc4, 32'h4C);
    check("h_rd", 32'(imem.ins_rd), 32'h0);
    idle();
    rst_n = 1'b0;
    #1;
    check("h_clr", 32'(halted), 32'h0);
    check("h_clr_pc", pc, 32'h0);
    #2 rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the multicycle CPU, sitting directly upstream of the control unit. It holds the PC, the instruction register (IR) and the latched PC+4, computes the next PC from the control unit's PCSrc selection, and feeds `opcode` and the decoded instruction fields to the control unit, register file and extender. It also provides sticky halt and misalignment status and a retired-fetch counter.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value after reset; must be word-aligned.
- `HALT_OPCODE`, 6'b111111, opcode that freezes the fetch unit.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `PCWre`  in  1  PC write enable from control unit.
- `IRWre`  in  1  IR write enable from control unit.
- `InsMemRW`  in  1  instruction memory read enable from control unit.
- `PCSrc`  in  2  next-PC select.
- `ext_imm`  in  32  sign-extended immediate from extender.
- `rs_data`  in  32  register-file rs read data, used as the `jr` target.
- `ins_rdata`  in  32  instruction memory read data, combinational from `ins_addr`.
- `ins_addr`  out  32  instruction memory address, equal to `pc`.
- `ins_rd`  out  1  instruction memory read strobe: `InsMemRW & ~halted`.
- `pc`  out  32  current PC.
- `pc4`  out  32  PC+4 latched at IR load; used for `jal` writeback and branches.
- `ir`  out  32  instruction register.
- `opcode`  out  6  `ir[31:26]`.
- `rs`, `rt`, `rd`  out  5 each  `ir[25:21]`, `ir[20:16]`, `ir[15:11]`.
- `imm16`  out  16  `ir[15:0]`.
- `jaddr`  out  26  `ir[25:0]`.
- `halted`  out  1  sticky halt flag.
- `misalign`  out  1  sticky misaligned-target flag.
- `instr_count`  out  32  count of IR loads.

## Operation
**Reset.** While `reset` is 0, regardless of `clk`:
- `pc = RESET_PC`
- `pc4 = 0`, `ir = 0`, `halted = 0`, `misalign = 0`, `instr_count = 0`

**IR load.** On a rising edge with `IRWre & InsMemRW & ~halted`:
- `ir <= ins_rdata`
- `pc4 <= pc + 4`
- `instr_count <= instr_count + 1` (wraps modulo 2^32)

`IRWre` without `InsMemRW` leaves IR, `pc4` and the counter unchanged.

**PC update.** On a rising edge with `PCWre & ~halted`, `pc <= target`, where target depends on `PCSrc`:
- 00: `pc + 4`
- 01: `pc4 + (ext_imm << 2)` (branch)
- 10: `rs_data` (jr)
- 11: `{pc4[31:28], jaddr, 2'b00}` (j/jal)

All arithmetic is 32-bit and discards carries.

**Misalignment.** If `target[1:0] != 0`:
- `pc` is written with `target & ~32'h3`.
- `misalign` is set and stays set until reset.

**Halt.** When `opcode == HALT_OPCODE`, `halted` is set on the next rising edge. Once set:
- `PCWre` and `IRWre` are ignored and `ins_rd` is 0.
- PC, IR and `pc4` freeze; only reset clears the halt.

**Simultaneous events.**
- `PCWre` and `IRWre` in the same cycle: IR takes `ins_rdata` fetched at the old `pc`, and `pc4` takes old `pc + 4`. PCSrc targets use the pre-edge `pc4`.

## Timing
- All state is registered on the rising `clk` edge; reset is asynchronous assert, synchronous release.
- Next-PC target is combinational from current `pc`, `pc4`, `ir`, `ext_imm` and `rs_data`. It is one mux plus an adder deep.
- IR load latency: `ir` and `opcode` are valid one cycle after the `IRWre` edge. The control unit decodes them in its following state.
- `halted` asserts one cycle after the halt opcode appears in `ir`.
- Reset asserted mid-instruction aborts it; no partial update survives.

## Structure
- Shared package `cpu_pkg`:
  - PCSrc encodings: `PC_NEXT=2'b00`, `PC_BRANCH=2'b01`, `PC_JR=2'b10`, `PC_JUMP=2'b11`.
  - `HALT_OPCODE` default.
  - `RESET_PC` default.
  - Instruction field bit positions.
- One sub-module, `next_pc_mux`: purely combinational target and alignment computation. It takes `pc`, `pc4`, `ext_imm`, `rs_data`, `jaddr` and `PCSrc`, and produces the aligned target and a misaligned bit.
- Registers, halt and counter stay in `fetch_unit`.

## Test plan
- **Reset:** assert `reset=0` mid-cycle with `pc` at 0x40 → `pc=0x0`, `ir=0`, counter 0, flags 0 immediately, without waiting for a clock edge.
- **Sequential fetch:** `ins_rdata=0x0022_0820`, pulse `IRWre`+`InsMemRW`, then `PCWre` with `PCSrc=00` → `ir=0x0022_0820`, `pc4=0x4`, `pc=0x4`, `instr_count=1`.
- **Branch:** `pc=0x10`, load IR, then `ext_imm=0xFFFF_FFFE`, `PCSrc=01` → `pc=0x0C`.
- **Jump:** load `ir=0x0800_0010`, then `PCSrc=11` → `pc=0x40`.
- **jr misaligned:** `rs_data=0x0000_0022`, `PCSrc=10` → `pc=0x20` and `misalign=1`, still set after 10 further fetches.
- **Halt:** load `ir=0xFC00_0000` → `halted=1` next cycle; further `PCWre`/`IRWre` pulses leave `pc`, `ir` and `instr_count` unchanged and `ins_rd=0`; reset clears the halt.
